// File: rtl/multicycle_control_fsm.sv
// Moore control unit for the multicycle RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/write-back and drives the datapath enables and selects.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_XOR = 3'b100;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  state_e  state_q;
  state_e  state_d;
  alu_op_e alu_op;
  logic    pc_update;
  logic    branch;
  logic    ir_write_raw;
  logic    mem_write_raw;
  logic    reg_write_raw;
  logic    op_legal;

  assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_IALU) || (op == OP_BEQ) || (op == OP_JAL);

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control
  always_comb begin
    state_d       = S_FETCH;
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    InstrDone     = 1'b0;
    Illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        state_d      = S_DECODE;
        ir_write_raw = 1'b1;
        pc_update    = 1'b1;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
        Illegal   = !op_legal;
        InstrDone = !op_legal;
      end
      S_MEMADR: begin
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        state_d   = S_MEMWB;
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        state_d       = S_FETCH;
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
        InstrDone     = 1'b1;
      end
      S_MEMWRITE: begin
        state_d       = S_FETCH;
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        InstrDone     = 1'b1;
      end
      S_EXECUTER: begin
        state_d = S_ALUWB;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        state_d = S_ALUWB;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        state_d       = S_FETCH;
        ResultSrc     = RES_ALUOUT;
        reg_write_raw = 1'b1;
        InstrDone     = 1'b1;
      end
      S_JAL: begin
        state_d   = S_ALUWB;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        state_d   = S_FETCH;
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        branch    = 1'b1;
        InstrDone = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // ALU operation decode from ALUOp and the funct fields
  always_comb begin
    ALUControl = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD: ALUControl = ALUC_ADD;
      ALUOP_SUB: ALUControl = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] && funct7) ? ALUC_SUB : ALUC_ADD;
          3'b010:  ALUControl = ALUC_SLT;
          3'b100:  ALUControl = ALUC_XOR;
          3'b110:  ALUControl = ALUC_OR;
          3'b111:  ALUControl = ALUC_AND;
          default: ALUControl = ALUC_ADD;
        endcase
      end
      default: ALUControl = ALUC_ADD;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_LW, OP_IALU: ImmSrc = 3'b000;
      OP_SW:          ImmSrc = 3'b001;
      OP_BEQ:         ImmSrc = 3'b010;
      OP_JAL:         ImmSrc = 3'b011;
      default:        ImmSrc = 3'b000;
    endcase
  end

  // Write enables are held off for the whole time reset is asserted
  assign PCWrite  = rst_n & (pc_update | (branch & Zero));
  assign IRWrite  = rst_n & ir_write_raw;
  assign MemWrite = rst_n & mem_write_raw;
  assign RegWrite = rst_n & reg_write_raw;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm against a
// per-instruction state-sequence and control-table reference model.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       InstrDone;
  logic       Illegal;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] IALU = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       irw;
    logic       mw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       done;
    logic       ill;
  } exp_t;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .InstrDone(InstrDone), .Illegal(Illegal),
    .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RTY) || (o == IALU) || (o == BEQ) || (o == JAL);
  endfunction

  // Expected controls for one cycle, written from the instruction's meaning
  function automatic exp_t model(input int s, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z);
    exp_t e;
    logic [2:0] fn;
    e = '0;
    case (o)
      SW:      e.imm = 3'd1;
      BEQ:     e.imm = 3'd2;
      JAL:     e.imm = 3'd3;
      default: e.imm = 3'd0;
    endcase
    case (f3)
      3'd0:    fn = (o == RTY && f7) ? 3'd1 : 3'd0;
      3'd2:    fn = 3'd5;
      3'd4:    fn = 3'd4;
      3'd6:    fn = 3'd3;
      3'd7:    fn = 3'd2;
      default: fn = 3'd0;
    endcase
    case (s)
      0:  begin e.irw = 1; e.pcw = 1; e.b = 2; e.rs = 2; end
      1:  begin e.a = 1; e.b = 1; e.ill = !is_legal(o); e.done = !is_legal(o); end
      2:  begin e.a = 2; e.b = 1; end
      3:  begin e.adr = 1; end
      4:  begin e.rs = 1; e.rw = 1; e.done = 1; end
      5:  begin e.adr = 1; e.mw = 1; e.done = 1; end
      6:  begin e.a = 2; e.alu = fn; end
      7:  begin e.a = 2; e.b = 1; e.alu = fn; end
      8:  begin e.rw = 1; e.done = 1; end
      9:  begin e.a = 1; e.b = 2; e.pcw = 1; end
      10: begin e.a = 2; e.alu = 3'd1; e.pcw = z; e.done = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check_cycle(input int s, input logic [6:0] o);
    exp_t e;
    e = model(s, o, funct3, funct7, Zero);
    check($sformatf("State op=%b", o), 8'(State), 8'(s));
    check($sformatf("PCWrite s%0d", s), 8'(PCWrite), 8'(e.pcw));
    check($sformatf("AdrSrc s%0d", s), 8'(AdrSrc), 8'(e.adr));
    check($sformatf("IRWrite s%0d", s), 8'(IRWrite), 8'(e.irw));
    check($sformatf("MemWrite s%0d", s), 8'(MemWrite), 8'(e.mw));
    check($sformatf("RegWrite s%0d", s), 8'(RegWrite), 8'(e.rw));
    check($sformatf("ResultSrc s%0d", s), 8'(ResultSrc), 8'(e.rs));
    check($sformatf("ALUSrcA s%0d", s), 8'(ALUSrcA), 8'(e.a));
    check($sformatf("ALUSrcB s%0d", s), 8'(ALUSrcB), 8'(e.b));
    check($sformatf("ALUControl s%0d f3=%0d f7=%0d", s, funct3, funct7), 8'(ALUControl), 8'(e.alu));
    check($sformatf("ImmSrc s%0d", s), 8'(ImmSrc), 8'(e.imm));
    check($sformatf("InstrDone s%0d", s), 8'(InstrDone), 8'(e.done));
    check($sformatf("Illegal s%0d", s), 8'(Illegal), 8'(e.ill));
  endtask

  task automatic state_seq(input logic [6:0] o, output int seq[$]);
    seq = {0, 1};
    case (o)
      LW:   seq = {seq, 2, 3, 4};
      SW:   seq = {seq, 2, 5};
      RTY:  seq = {seq, 6, 8};
      IALU: seq = {seq, 7, 8};
      JAL:  seq = {seq, 9, 8};
      BEQ:  seq = {seq, 10};
      default: ;
    endcase
  endtask

  // Starts just after the edge entering FETCH; zmode 0 random, 1 force Zero=1, 2 force Zero=0
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zmode);
    int seq[$];
    state_seq(o, seq);
    op = o; funct3 = f3; funct7 = f7;
    foreach (seq[k]) begin
      Zero = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check_cycle(seq[k], o);
      @(posedge clk); #1;
    end
  endtask

  // Run 'steps' cycles of an instruction, then assert reset in the middle of the next one
  task automatic mid_reset(input logic [6:0] o, input int steps);
    op = o; funct3 = 3'd0; funct7 = 1'b0; Zero = 1'b0;
    repeat (steps) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check($sformatf("wen before reset op=%b", o), 8'(MemWrite | RegWrite), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("MemWrite in reset", 8'(MemWrite), 8'd0);
    check("RegWrite in reset", 8'(RegWrite), 8'd0);
    check("PCWrite in reset", 8'(PCWrite), 8'd0);
    check("IRWrite in reset", 8'(IRWrite), 8'd0);
    check("State in reset", 8'(State), 8'd0);
    @(posedge clk); #1;
    check("State held in reset", 8'(State), 8'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] o;
    logic [6:0] legal_ops [6];
    legal_ops = '{LW, SW, RTY, IALU, BEQ, JAL};
    rst_n = 1'b0; op = RTY; funct3 = 3'd0; funct7 = 1'b0; Zero = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset State", 8'(State), 8'd0);
    check("reset PCWrite", 8'(PCWrite), 8'd0);
    check("reset IRWrite", 8'(IRWrite), 8'd0);
    check("reset MemWrite", 8'(MemWrite), 8'd0);
    check("reset RegWrite", 8'(RegWrite), 8'd0);
    check("reset ALUSrcB", 8'(ALUSrcB), 8'd2);
    check("reset ResultSrc", 8'(ResultSrc), 8'd2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("release IRWrite", 8'(IRWrite), 8'd1);
    check("release PCWrite", 8'(PCWrite), 8'd1);

    run_instr(LW, 3'd2, 1'b0, 0);
    run_instr(RTY, 3'd0, 1'b1, 0);
    run_instr(RTY, 3'd0, 1'b0, 0);
    run_instr(IALU, 3'd0, 1'b1, 0);
    run_instr(RTY, 3'd7, 1'b0, 0);
    run_instr(BEQ, 3'd0, 1'b0, 1);
    run_instr(BEQ, 3'd0, 1'b0, 2);
    run_instr(JAL, 3'd5, 1'b1, 0);
    run_instr(7'b0000000, 3'd0, 1'b0, 0);
    run_instr(SW, 3'd2, 1'b0, 0);

    mid_reset(SW, 3);
    mid_reset(LW, 4);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) < 6) begin
        o = legal_ops[$urandom_range(0, 5)];
      end else begin
        do o = 7'($urandom); while (is_legal(o));
      end
      run_instr(o, 3'($urandom), 1'($urandom), 0);
    end

    @(negedge clk);
    check("final State", 8'(State), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequential control unit for the multicycle RV32I-subset datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles, sharing one ALU and one memory port. It replaces the single-cycle control path and drives the datapath's enable and mux-select lines. It reuses the existing `ALUControl`/`ImmSrc` encodings so the datapath ALU and immediate extender are unchanged.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: opcode, `instr[6:0]`, taken from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7` in 1: `instr[30]`.
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction register and OldPC enable.
- `MemWrite` out 1: data memory write.
- `RegWrite` out 1: register file write.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB` out 2: ALU B select. 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ALUControl` out 3: ALU operation. add 000, sub 001, and 010, or 011, xor 100, slt 101.
- `ImmSrc` out 3: immediate type. I 000, S 001, B 010, J 011.
- `InstrDone` out 1: high during the last cycle of each instruction.
- `Illegal` out 1: high during DECODE when the opcode is unsupported.
- `State` out 4: current state, for debug.

## Operation
- **State encoding:** FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, JAL 9, BEQ 10. Codes 11–15 go to FETCH on the next edge and drive all enables 0.
- **Supported opcodes:** lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE: lw/sw→MEMADR, R→EXECUTER, I-ALU→EXECUTEI, jal→JAL, beq→BEQ. Any other opcode→FETCH with `Illegal`=1.
  - MEMADR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH.
  - JAL→ALUWB.
  - BEQ→FETCH.
- **Per-state outputs.** Signals not listed are 0, and `ALUOp` defaults to add.
  - FETCH: `AdrSrc`=0, `IRWrite`=1, A=00, B=10, `ResultSrc`=10, PCUpdate=1, ALUOp add.
  - DECODE: A=01, B=01, ALUOp add (computes the branch target).
  - MEMADR: A=10, B=01, ALUOp add.
  - MEMREAD: `AdrSrc`=1, `ResultSrc`=00.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1.
  - MEMWRITE: `AdrSrc`=1, `MemWrite`=1.
  - EXECUTER: A=10, B=00, ALUOp funct.
  - EXECUTEI: A=10, B=01, ALUOp funct.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1.
  - JAL: A=01, B=10, ALUOp add, `ResultSrc`=00, PCUpdate=1.
  - BEQ: A=10, B=00, ALUOp sub, `ResultSrc`=00, Branch=1.
- **PC write:** `PCWrite` = PCUpdate | (Branch & `Zero`).
- **ALU decode:** `ALUOp` add→000, sub→001. For ALUOp funct, decode `funct3`:
  - 000 → sub (001) if `op[5]` & `funct7`, else add (000).
  - 010 → slt (101).
  - 100 → xor (100).
  - 110 → or (011).
  - 111 → and (010).
  - Other values → 000.
- **`ImmSrc`:** decoded from `op` in every state. lw and I-ALU→000, sw→001, beq→010, jal→011, other→000.
- **`InstrDone`:** asserted in MEMWB, MEMWRITE, ALUWB, BEQ, and DECODE when the opcode is illegal.

## Timing
- The state register updates on the `clk` rising edge. All outputs are combinational from `State`, `op`, `funct3`, `funct7` and `Zero`.
- **Reset:** `rst_n` low forces `State` = FETCH immediately, asynchronously.
  - While `rst_n` is low, `PCWrite`, `IRWrite`, `MemWrite` and `RegWrite` are forced to 0.
  - All other outputs show FETCH values.
  - The first fetch occurs on the first rising edge after `rst_n` rises.
- **Reset mid-instruction:** the instruction is abandoned with no further write enables. No partial `RegWrite` or `MemWrite` may occur after `rst_n` falls.
- **Latency (cycles, FETCH to last state inclusive):** lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3, illegal 2.
- `op` and `funct` fields are sampled only while the IR is stable. The IR changes only at the edge ending FETCH.
- `Zero` is used only in BEQ, in the same cycle.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → `State`=0 and all four write enables 0. Release `rst_n` → `IRWrite`=1 and `PCWrite`=1 in the first cycle.
- **lw (op 0000011):**
  - `State` sequence 0,1,2,3,4,0.
  - `AdrSrc`=1 in state 3.
  - `RegWrite`=1 with `ResultSrc`=01 only in state 4.
  - `InstrDone` high in state 4 only.
- **R-type:**
  - `funct3`=000, `funct7`=1 → `ALUControl`=001 in EXECUTER. `funct7`=0 → 000.
  - I-ALU with `funct3`=000, `funct7`=1 → 000 (addi).
  - `funct3`=111 → 010.
- **beq:**
  - With `Zero`=1 in BEQ → `PCWrite`=1 and `ALUControl`=001.
  - With `Zero`=0 → `PCWrite`=0.
  - Both cases take 3 cycles.
- **jal (1101111):**
  - Sequence 0,1,9,8,0.
  - `PCWrite`=1 in state 9.
  - `RegWrite`=1 in state 8.
  - `ImmSrc`=011.
- **Illegal and reset mid-instruction:**
  - Illegal: op 0000000 → `Illegal`=1 and `InstrDone`=1 in DECODE, then back to FETCH with no write enables.
  - Reset mid-instruction: drop `rst_n` during MEMWRITE → `MemWrite` falls to 0 immediately and `State`=0.
